// File: rtl/ex_mem_wb_regs.sv
// EX/MEM and MEM/WB pipeline registers with stall, flush-to-bubble and x0 write suppression.
// Optional BUBBLE_CNT_EN macro adds a saturating Bubble_Count of flush-inserted bubbles.
module ex_mem_wb_regs (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        EX_RegWrite,
    input  logic        EX_MemWrite,
    input  logic        EX_MemRead,
    input  logic        EX_MemtoReg,
    input  logic [4:0]  EX_Rd,
    input  logic [31:0] EX_ALU_Result,
    input  logic [31:0] EX_Rs2_Data,
    input  logic [31:0] Mem_Read_Data,
    output logic        EX_MEM_RegWrite,
    output logic        EX_MEM_MemWrite,
    output logic        EX_MEM_MemRead,
    output logic        EX_MEM_MemtoReg,
    output logic [4:0]  EX_MEM_Rd,
    output logic [31:0] EX_MEM_ALU_Result,
    output logic [31:0] EX_MEM_Store_Data,
    output logic        MEM_WB_RegWrite,
    output logic [4:0]  MEM_WB_Rd,
    output logic [31:0] MEM_WB_WB_Data
`ifdef BUBBLE_CNT_EN
    ,
    output logic [15:0] Bubble_Count
`endif
);

    logic [31:0] wb_data;

    // Mem_Read_Data feeds only the MEM/WB register, so no input reaches an output combinationally.
    always_comb begin
        wb_data = EX_MEM_MemtoReg ? Mem_Read_Data : EX_MEM_ALU_Result;
    end

    // NOTE: every register here uses non-blocking assignment so MEM/WB samples the
    // EX/MEM contents from before this edge, not the values being loaded on it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            EX_MEM_RegWrite   <= 1'b0;
            EX_MEM_MemWrite   <= 1'b0;
            EX_MEM_MemRead    <= 1'b0;
            EX_MEM_MemtoReg   <= 1'b0;
            EX_MEM_Rd         <= 5'd0;
            EX_MEM_ALU_Result <= 32'd0;
            EX_MEM_Store_Data <= 32'd0;
        end else if (!Stall) begin
            if (Flush) begin
                EX_MEM_RegWrite   <= 1'b0;
                EX_MEM_MemWrite   <= 1'b0;
                EX_MEM_MemRead    <= 1'b0;
                EX_MEM_MemtoReg   <= 1'b0;
                EX_MEM_Rd         <= 5'd0;
                EX_MEM_ALU_Result <= 32'd0;
                EX_MEM_Store_Data <= 32'd0;
            end else begin
                // A write to x0 is dropped here so forwarding never matches on it.
                EX_MEM_RegWrite   <= EX_RegWrite && (EX_Rd != 5'd0);
                EX_MEM_MemWrite   <= EX_MemWrite;
                EX_MEM_MemRead    <= EX_MemRead;
                EX_MEM_MemtoReg   <= EX_MemtoReg;
                EX_MEM_Rd         <= EX_Rd;
                EX_MEM_ALU_Result <= EX_ALU_Result;
                EX_MEM_Store_Data <= EX_Rs2_Data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            MEM_WB_RegWrite <= 1'b0;
            MEM_WB_Rd       <= 5'd0;
            MEM_WB_WB_Data  <= 32'd0;
        end else if (!Stall) begin
            MEM_WB_RegWrite <= EX_MEM_RegWrite;
            MEM_WB_Rd       <= EX_MEM_Rd;
            MEM_WB_WB_Data  <= wb_data;
        end
    end

`ifdef BUBBLE_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Bubble_Count <= 16'd0;
        end else if (Flush && !Stall && (Bubble_Count != 16'hFFFF)) begin
            Bubble_Count <= Bubble_Count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ex_mem_wb_regs.sv
// Scoreboard bench for ex_mem_wb_regs: expected stage contents are queued as stimulus is
// applied and compared one edge later. Define BUBBLE_CNT_EN to also check Bubble_Count.
module tb_ex_mem_wb_regs;

    typedef struct packed {
        logic        rw;
        logic        mw;
        logic        mr;
        logic        mtr;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] st;
    } ex_t;

    typedef struct packed {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Stall, Flush;
    logic        EX_RegWrite, EX_MemWrite, EX_MemRead, EX_MemtoReg;
    logic [4:0]  EX_Rd;
    logic [31:0] EX_ALU_Result, EX_Rs2_Data, Mem_Read_Data;
    logic        EX_MEM_RegWrite, EX_MEM_MemWrite, EX_MEM_MemRead, EX_MEM_MemtoReg;
    logic [4:0]  EX_MEM_Rd;
    logic [31:0] EX_MEM_ALU_Result, EX_MEM_Store_Data;
    logic        MEM_WB_RegWrite;
    logic [4:0]  MEM_WB_Rd;
    logic [31:0] MEM_WB_WB_Data;
`ifdef BUBBLE_CNT_EN
    logic [15:0] Bubble_Count;
`endif

    int checks = 0;
    int failures = 0;

    ex_t ex_q[$];
    wb_t wb_q[$];
    ex_t cur_ex;
    wb_t cur_wb;
    ex_t ex_e;
    wb_t wb_e;
    logic [15:0] bubble_exp;

    ex_mem_wb_regs dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .Stall             (Stall),
        .Flush             (Flush),
        .EX_RegWrite       (EX_RegWrite),
        .EX_MemWrite       (EX_MemWrite),
        .EX_MemRead        (EX_MemRead),
        .EX_MemtoReg       (EX_MemtoReg),
        .EX_Rd             (EX_Rd),
        .EX_ALU_Result     (EX_ALU_Result),
        .EX_Rs2_Data       (EX_Rs2_Data),
        .Mem_Read_Data     (Mem_Read_Data),
        .EX_MEM_RegWrite   (EX_MEM_RegWrite),
        .EX_MEM_MemWrite   (EX_MEM_MemWrite),
        .EX_MEM_MemRead    (EX_MEM_MemRead),
        .EX_MEM_MemtoReg   (EX_MEM_MemtoReg),
        .EX_MEM_Rd         (EX_MEM_Rd),
        .EX_MEM_ALU_Result (EX_MEM_ALU_Result),
        .EX_MEM_Store_Data (EX_MEM_Store_Data),
        .MEM_WB_RegWrite   (MEM_WB_RegWrite),
        .MEM_WB_Rd         (MEM_WB_Rd),
        .MEM_WB_WB_Data    (MEM_WB_WB_Data)
`ifdef BUBBLE_CNT_EN
        ,
        .Bubble_Count      (Bubble_Count)
`endif
    );

    always #5 clk = ~clk;

    // Data memory stand-in: fixed contents at 0x100, address-derived pattern elsewhere.
    function automatic logic [31:0] mem_fn(input logic [31:0] addr);
        return (addr == 32'h100) ? 32'h0000DEAD : (addr ^ 32'h5A5A5A5A);
    endfunction

    assign Mem_Read_Data = mem_fn(EX_MEM_ALU_Result);

    function automatic ex_t capture(input ex_t i);
        ex_t r;
        r = i;
        r.rw = i.rw && (i.rd != 5'd0);
        return r;
    endfunction

    function automatic wb_t wb_of(input ex_t e);
        wb_t w;
        w.rw = e.rw;
        w.rd = e.rd;
        w.data = e.mtr ? mem_fn(e.alu) : e.alu;
        return w;
    endfunction

    function automatic ex_t dut_ex();
        return {EX_MEM_RegWrite, EX_MEM_MemWrite, EX_MEM_MemRead, EX_MEM_MemtoReg,
                EX_MEM_Rd, EX_MEM_ALU_Result, EX_MEM_Store_Data};
    endfunction

    function automatic wb_t dut_wb();
        return {MEM_WB_RegWrite, MEM_WB_Rd, MEM_WB_WB_Data};
    endfunction

    function automatic ex_t mk(input logic rw, mw, mr, mtr, input logic [4:0] rd,
                               input logic [31:0] alu, st);
        return {rw, mw, mr, mtr, rd, alu, st};
    endfunction

    // Drives one cycle of stimulus, queues the expected stage contents after the edge,
    // then waits until just past that edge.
    task automatic drive_cycle(input ex_t ins, input logic stall, input logic flush);
        EX_RegWrite   = ins.rw;
        EX_MemWrite   = ins.mw;
        EX_MemRead    = ins.mr;
        EX_MemtoReg   = ins.mtr;
        EX_Rd         = ins.rd;
        EX_ALU_Result = ins.alu;
        EX_Rs2_Data   = ins.st;
        Stall         = stall;
        Flush         = flush;
        if (!stall) begin
            cur_wb = wb_of(cur_ex);
            cur_ex = flush ? '0 : capture(ins);
            if (flush && bubble_exp != 16'hFFFF) bubble_exp = bubble_exp + 16'd1;
        end
        ex_q.push_back(cur_ex);
        wb_q.push_back(cur_wb);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic stall, input logic flush);
        rst_n = 1'b0;
        Stall = stall;
        Flush = flush;
        EX_RegWrite = 1'b1; EX_MemWrite = 1'b1; EX_MemRead = 1'b1; EX_MemtoReg = 1'b1;
        EX_Rd = 5'd17; EX_ALU_Result = 32'hFFFF0000; EX_Rs2_Data = 32'h12345678;
        ex_q.delete();
        wb_q.delete();
        cur_ex = '0;
        cur_wb = '0;
        bubble_exp = 16'd0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            apply_reset(1'b0, 1'b0);
            checks++;
            if (dut_ex() !== ex_t'(0)) begin
                failures++;
                $display("FAIL reset ex_mem edge %0d: got %h want 0", i, dut_ex());
            end
            checks++;
            if (dut_wb() !== wb_t'(0)) begin
                failures++;
                $display("FAIL reset mem_wb edge %0d: got %h want 0", i, dut_wb());
            end
        end
`ifdef BUBBLE_CNT_EN
        checks++;
        if (Bubble_Count !== 16'd0) begin
            failures++;
            $display("FAIL reset bubble_count: got %0d want 0", Bubble_Count);
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_passthrough();
        ex_t tbl[5];
        tbl[0] = mk(1, 0, 0, 0, 5'd5, 32'h10, 32'h0);
        tbl[1] = mk(1, 0, 0, 0, 5'd9, 32'h1234, 32'h55);
        tbl[2] = mk(0, 1, 0, 0, 5'd2, 32'h200, 32'hCAFE);
        tbl[3] = mk(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        tbl[4] = mk(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            drive_cycle(tbl[i], 1'b0, 1'b0);
            ex_e = ex_q.pop_front();
            wb_e = wb_q.pop_front();
            checks++;
            if (dut_ex() !== ex_e) begin
                failures++;
                $display("FAIL passthrough ex_mem step %0d: got %h want %h", i, dut_ex(), ex_e);
            end
            checks++;
            if (dut_wb() !== wb_e) begin
                failures++;
                $display("FAIL passthrough mem_wb step %0d: got %h want %h", i, dut_wb(), wb_e);
            end
        end
    endtask

    task automatic test_load();
        ex_t tbl[4];
        tbl[0] = mk(1, 0, 1, 1, 5'd3, 32'h100, 32'h0);
        tbl[1] = mk(1, 0, 1, 1, 5'd4, 32'h40, 32'h0);
        tbl[2] = mk(1, 0, 0, 0, 5'd11, 32'h100, 32'h0);
        tbl[3] = mk(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            drive_cycle(tbl[i], 1'b0, 1'b0);
            ex_e = ex_q.pop_front();
            wb_e = wb_q.pop_front();
            checks++;
            if (dut_ex() !== ex_e) begin
                failures++;
                $display("FAIL load ex_mem step %0d: got %h want %h", i, dut_ex(), ex_e);
            end
            checks++;
            if (dut_wb() !== wb_e) begin
                failures++;
                $display("FAIL load mem_wb step %0d: got %h want %h", i, dut_wb(), wb_e);
            end
        end
    endtask

    task automatic test_x0();
        ex_t tbl[3];
        tbl[0] = mk(1, 0, 0, 0, 5'd0, 32'h77, 32'h0);
        tbl[1] = mk(1, 0, 1, 1, 5'd0, 32'h100, 32'h0);
        tbl[2] = mk(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(tbl[i], 1'b0, 1'b0);
            ex_e = ex_q.pop_front();
            wb_e = wb_q.pop_front();
            checks++;
            if (dut_ex() !== ex_e) begin
                failures++;
                $display("FAIL x0 ex_mem step %0d: got %h want %h", i, dut_ex(), ex_e);
            end
            checks++;
            if (dut_wb() !== wb_e) begin
                failures++;
                $display("FAIL x0 mem_wb step %0d: got %h want %h", i, dut_wb(), wb_e);
            end
        end
    endtask

    task automatic test_back_to_back();
        ex_t tbl[4];
        tbl[0] = mk(1, 0, 0, 0, 5'd6, 32'hAAAA0001, 32'h0);
        tbl[1] = mk(1, 0, 0, 0, 5'd6, 32'hAAAA0002, 32'h0);
        tbl[2] = mk(1, 0, 1, 1, 5'd6, 32'h80, 32'h0);
        tbl[3] = mk(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            drive_cycle(tbl[i], 1'b0, 1'b0);
            ex_e = ex_q.pop_front();
            wb_e = wb_q.pop_front();
            checks++;
            if (dut_ex() !== ex_e) begin
                failures++;
                $display("FAIL back_to_back ex_mem step %0d: got %h want %h", i, dut_ex(), ex_e);
            end
            checks++;
            if (dut_wb() !== wb_e) begin
                failures++;
                $display("FAIL back_to_back mem_wb step %0d: got %h want %h", i, dut_wb(), wb_e);
            end
        end
    endtask

    // Store held under a 3-cycle stall with Flush asserted, then the held Flush takes effect.
    task automatic test_stall();
        ex_t tbl[7];
        logic st[7];
        logic fl[7];
        tbl[0] = mk(1, 0, 0, 0, 5'd8, 32'h88, 32'h0);         st[0] = 0; fl[0] = 0;
        tbl[1] = mk(0, 1, 0, 0, 5'd7, 32'h300, 32'hBEEF);     st[1] = 0; fl[1] = 0;
        tbl[2] = mk(1, 0, 1, 1, 5'd12, 32'h999, 32'h1);       st[2] = 1; fl[2] = 1;
        tbl[3] = mk(1, 1, 1, 1, 5'd13, 32'h777, 32'h2);       st[3] = 1; fl[3] = 1;
        tbl[4] = mk(1, 0, 0, 0, 5'd14, 32'h555, 32'h3);       st[4] = 1; fl[4] = 1;
        tbl[5] = mk(1, 0, 0, 0, 5'd15, 32'h444, 32'h4);       st[5] = 0; fl[5] = 1;
        tbl[6] = mk(1, 0, 0, 0, 5'd16, 32'h333, 32'h5);       st[6] = 0; fl[6] = 0;
        for (int i = 0; i < 7; i++) begin
            drive_cycle(tbl[i], st[i], fl[i]);
            ex_e = ex_q.pop_front();
            wb_e = wb_q.pop_front();
            checks++;
            if (dut_ex() !== ex_e) begin
                failures++;
                $display("FAIL stall ex_mem step %0d: got %h want %h", i, dut_ex(), ex_e);
            end
            checks++;
            if (dut_wb() !== wb_e) begin
                failures++;
                $display("FAIL stall mem_wb step %0d: got %h want %h", i, dut_wb(), wb_e);
            end
`ifdef BUBBLE_CNT_EN
            checks++;
            if (Bubble_Count !== bubble_exp) begin
                failures++;
                $display("FAIL stall bubble_count step %0d: got %0d want %0d", i, Bubble_Count, bubble_exp);
            end
`endif
        end
    endtask

    task automatic test_flush_reset();
        apply_reset(1'b0, 1'b0);
        rst_n = 1'b1;
        drive_cycle(mk(1, 0, 0, 0, 5'd21, 32'h21, 32'h0), 1'b0, 1'b0);
        ex_e = ex_q.pop_front();
        wb_e = wb_q.pop_front();
        drive_cycle(mk(1, 1, 1, 1, 5'd22, 32'h22, 32'h22), 1'b0, 1'b1);
        ex_e = ex_q.pop_front();
        wb_e = wb_q.pop_front();
        checks++;
        if (dut_ex() !== ex_e) begin
            failures++;
            $display("FAIL flush ex_mem: got %h want %h", dut_ex(), ex_e);
        end
        checks++;
        if (dut_wb() !== wb_e) begin
            failures++;
            $display("FAIL flush mem_wb: got %h want %h", dut_wb(), wb_e);
        end
`ifdef BUBBLE_CNT_EN
        checks++;
        if (Bubble_Count !== 16'd1) begin
            failures++;
            $display("FAIL flush bubble_count: got %0d want 1", Bubble_Count);
        end
`endif
        drive_cycle(mk(0, 1, 0, 0, 5'd23, 32'h23, 32'h2323), 1'b0, 1'b0);
        ex_e = ex_q.pop_front();
        wb_e = wb_q.pop_front();
        apply_reset(1'b1, 1'b1);
        checks++;
        if (dut_ex() !== ex_t'(0) || dut_wb() !== wb_t'(0)) begin
            failures++;
            $display("FAIL reset_in_stall: got ex %h wb %h want 0", dut_ex(), dut_wb());
        end
`ifdef BUBBLE_CNT_EN
        checks++;
        if (Bubble_Count !== 16'd0) begin
            failures++;
            $display("FAIL reset_in_stall bubble_count: got %0d want 0", Bubble_Count);
        end
`endif
        rst_n = 1'b1;
        drive_cycle(mk(1, 0, 0, 0, 5'd24, 32'h24, 32'h0), 1'b0, 1'b0);
        ex_e = ex_q.pop_front();
        wb_e = wb_q.pop_front();
        checks++;
        if (dut_ex() !== ex_e) begin
            failures++;
            $display("FAIL after_reset ex_mem: got %h want %h", dut_ex(), ex_e);
        end
    endtask

    task automatic test_random();
        ex_t ins;
        logic stall, flush;
        for (int i = 0; i < 40; i++) begin
            ins = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     5'($urandom_range(0, 31)),
                     ($urandom_range(0, 3) == 0) ? 32'h100 : $urandom(), $urandom());
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 4) == 0);
            drive_cycle(ins, stall, flush);
            ex_e = ex_q.pop_front();
            wb_e = wb_q.pop_front();
            checks++;
            if (dut_ex() !== ex_e) begin
                failures++;
                $display("FAIL random ex_mem step %0d: got %h want %h", i, dut_ex(), ex_e);
            end
            checks++;
            if (dut_wb() !== wb_e) begin
                failures++;
                $display("FAIL random mem_wb step %0d: got %h want %h", i, dut_wb(), wb_e);
            end
`ifdef BUBBLE_CNT_EN
            checks++;
            if (Bubble_Count !== bubble_exp) begin
                failures++;
                $display("FAIL random bubble_count step %0d: got %0d want %0d", i, Bubble_Count, bubble_exp);
            end
`endif
        end
    endtask

    initial begin
        rst_n = 1'b0;
        Stall = 1'b0;
        Flush = 1'b0;
        cur_ex = '0;
        cur_wb = '0;
        bubble_exp = 16'd0;
        test_reset();
        test_passthrough();
        test_load();
        test_x0();
        test_back_to_back();
        test_stall();
        test_flush_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_mem_wb_regs.md
EX_MEM_WB_REGS -- requirements
Module: ex_mem_wb_regs

Interface
REQ-001 SHALL provide ports: clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 SHALL provide: rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL provide: Stall  in  1  freeze both stages; Flush  in  1  load bubble into EX/MEM.
REQ-004 SHALL provide EX-stage inputs: EX_RegWrite, EX_MemWrite, EX_MemRead, EX_MemtoReg  in  1 each  control bits; EX_Rd  in  5  dest reg; EX_ALU_Result  in  32; EX_Rs2_Data  in  32  store data.
REQ-005 SHALL provide: Mem_Read_Data  in  32  combinational data-memory read of EX_MEM_ALU_Result.
REQ-006 SHALL provide outputs: EX_MEM_RegWrite, EX_MEM_MemWrite, EX_MEM_MemRead, EX_MEM_MemtoReg  out  1 each; EX_MEM_Rd  out  5; EX_MEM_ALU_Result  out  32; EX_MEM_Store_Data  out  32.
REQ-007 SHALL provide outputs: MEM_WB_RegWrite  out  1; MEM_WB_Rd  out  5; MEM_WB_WB_Data  out  32  write-back value.
REQ-008 SHALL provide, only with BUBBLE_CNT_EN: Bubble_Count  out  16  bubbles inserted since reset.
REQ-009 Outputs SHALL be driven directly from registers; no combinational input-to-output path.

Function
REQ-010 EX/MEM stage SHALL capture all EX_* inputs on each edge with Stall=0, Flush=0 (latency 1 cycle).
REQ-011 MEM/WB stage SHALL capture EX_MEM_RegWrite, EX_MEM_Rd and WB data on each edge with Stall=0 (latency 1 cycle from EX/MEM).
REQ-012 WB data SHALL be Mem_Read_Data when EX_MEM_MemtoReg=1, else EX_MEM_ALU_Result.
REQ-013 x0 rule: captured EX_MEM_RegWrite SHALL be EX_RegWrite AND (EX_Rd != 0); forwarding never sees a write to x0.
REQ-014 Flush=1, Stall=0: EX/MEM SHALL load bubble (all four control bits 0, Rd=0, data fields 0); MEM/WB advances normally.
REQ-015 Stall=1: both stages SHALL hold all values; Flush ignored that cycle (upstream holds Flush until Stall drops).
REQ-016 Stall and MemWrite: a held EX_MEM_MemWrite=1 SHALL remain asserted; memory write-once is the memory's responsibility.
REQ-017 Back-to-back writes to same Rd SHALL pass through unchanged; priority resolution belongs to the forwarding unit.
REQ-018 Stage "state" is valid/bubble only; a bubble is any entry with RegWrite=MemWrite=MemRead=0.

Reset
REQ-019 rst_n=0 at an edge SHALL clear every output register to 0 (both stages bubble), overriding Stall and Flush.
REQ-020 Reset asserted mid-stall SHALL discard held instruction; first edge after rst_n=1 captures EX inputs normally.
REQ-021 Bubble_Count SHALL reset to 0.

Configuration
REQ-022 Macro BUBBLE_CNT_EN SHALL, when defined, add Bubble_Count: +1 per edge with Flush=1, Stall=0, rst_n=1; saturates at 16'hFFFF.
REQ-023 Without BUBBLE_CNT_EN, port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-024 Passthrough: EX_RegWrite=1, EX_Rd=5, EX_ALU_Result=32'h10, MemtoReg=0 -> EX_MEM_Rd=5 after 1 edge; MEM_WB_Rd=5, MEM_WB_WB_Data=32'h10, MEM_WB_RegWrite=1 after 2 edges.
REQ-025 Load: MemtoReg=1, MemRead=1, Rd=3, Mem_Read_Data=32'hDEAD at EX/MEM -> MEM_WB_WB_Data=32'hDEAD, MEM_WB_RegWrite=1.
REQ-026 x0: EX_RegWrite=1, EX_Rd=0 -> EX_MEM_RegWrite=0, then MEM_WB_RegWrite=0.
REQ-027 Stall 3 cycles with EX_MEM_Rd=7, MemWrite=1 -> all outputs unchanged for 3 edges; Flush=1 during stall has no effect.
REQ-028 Flush then reset: Flush=1 one cycle -> EX/MEM bubble, Bubble_Count=1 (macro on); rst_n=0 during Stall=1 -> all outputs 0 next edge.
